// File: rtl/dram_rr_arbiter.sv
// Round-robin sequencer giving up to 4 cores one-at-a-time access to the single-port DRAM.
// Optional per-core grant counters (o_grant_cnt) when ARB_STATS_EN is defined.
module dram_rr_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [2:0]            i_noc,
    input  logic [3:0]            i_req,
    input  logic [3:0]            i_we,
    input  logic [4*ADDR_W-1:0]   i_addr,
    input  logic [4*DATA_W-1:0]   i_wdata,
    output logic [4*DATA_W-1:0]   o_rdata,
    output logic [3:0]            o_gnt,
    output logic [3:0]            o_done,
    output logic                  o_busy,
    output logic [ADDR_W-1:0]     o_dram_addr,
    output logic [DATA_W-1:0]     o_dram_data,
    output logic                  o_dram_rden,
    output logic                  o_dram_wren,
    input  logic [DATA_W-1:0]     i_dram_q
`ifdef ARB_STATS_EN
    ,
    output logic [4*16-1:0]       o_grant_cnt
`endif
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [1:0]          ptr, idx;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [CNT_W-1:0]    cnt;
    logic [4*DATA_W-1:0] rdata_q;

    logic [2:0] n_act;
    logic [3:0] eligible;
    logic       found;
    logic [1:0] pick;
    logic [1:0] cand;

    // Eligibility and rotating scan starting just after the last winner.
    always_comb begin
        n_act    = (i_noc > 3'd4) ? 3'd4 : i_noc;
        eligible = '0;
        found    = 1'b0;
        pick     = ptr;
        cand     = ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            eligible[k] = i_req[k] && (3'(k) < n_act);
        end
        for (int unsigned s = 1; s <= 4; s++) begin
            cand = ptr + 2'(s);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = lat_we ? S_DONE : S_WAIT;
            S_WAIT:  if (cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_IDLE;
            ptr       <= 2'd3;
            idx       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        idx       <= pick;
                        ptr       <= pick;
                        lat_we    <= i_we[pick];
                        lat_addr  <= i_addr[int'(pick)*ADDR_W +: ADDR_W];
                        lat_wdata <= i_wdata[int'(pick)*DATA_W +: DATA_W];
                    end
                end
                S_ISSUE: cnt <= CNT_W'(READ_LAT - 1);
                S_WAIT: begin
                    if (cnt == '0) rdata_q[int'(idx)*DATA_W +: DATA_W] <= i_dram_q;
                    else           cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = (state != S_IDLE);
    assign o_gnt       = o_busy ? (4'b0001 << idx) : 4'b0000;
    assign o_done      = (state == S_DONE) ? (4'b0001 << idx) : 4'b0000;
    assign o_dram_rden = (state == S_ISSUE) && !lat_we;
    assign o_dram_wren = (state == S_ISSUE) && lat_we;
    assign o_dram_addr = lat_addr;
    assign o_dram_data = lat_wdata;
    assign o_rdata     = rdata_q;

`ifdef ARB_STATS_EN
    logic [4*16-1:0] grant_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            grant_cnt_q <= '0;
        end else if (state == S_ISSUE && grant_cnt_q[int'(idx)*16 +: 16] != 16'hFFFF) begin
            grant_cnt_q[int'(idx)*16 +: 16] <= grant_cnt_q[int'(idx)*16 +: 16] + 16'd1;
        end
    end

    assign o_grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_dram_rr_arbiter.sv
// Randomized bench for dram_rr_arbiter against a transaction-level reference model.
// Connects o_grant_cnt and models the counters when ARB_STATS_EN is defined.
module tb_dram_rr_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int RL = 1;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic [2:0]         i_noc;
    logic [3:0]         i_req, i_we;
    logic [4*AW-1:0]    i_addr;
    logic [4*DW-1:0]    i_wdata;
    logic [4*DW-1:0]    o_rdata;
    logic [3:0]         o_gnt, o_done;
    logic               o_busy;
    logic [AW-1:0]      o_dram_addr;
    logic [DW-1:0]      o_dram_data;
    logic               o_dram_rden, o_dram_wren;
    logic [DW-1:0]      i_dram_q = '0;
`ifdef ARB_STATS_EN
    logic [63:0]        o_grant_cnt;
`endif

    always #5 i_clk = ~i_clk;

    dram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_noc(i_noc), .i_req(i_req), .i_we(i_we),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_gnt(o_gnt),
        .o_done(o_done), .o_busy(o_busy), .o_dram_addr(o_dram_addr),
        .o_dram_data(o_dram_data), .o_dram_rden(o_dram_rden),
        .o_dram_wren(o_dram_wren), .i_dram_q(i_dram_q)
`ifdef ARB_STATS_EN
        , .o_grant_cnt(o_grant_cnt)
`endif
    );

    // DRAM macro stand-in: 32 words, read data READ_LAT (=1) cycle after rden.
    logic [7:0] dram [32] = '{default: 8'h00};
    always @(posedge i_clk) begin
        if (o_dram_wren) dram[o_dram_addr[4:0]] <= o_dram_data;
        if (o_dram_rden) i_dram_q <= dram[o_dram_addr[4:0]];
    end

    int tests = 0;
    int fails = 0;
    int unsigned cyc = 0;
    bit auto_drop = 1'b1;

    // Reference model: one transaction at a time, tracked by its phase since ISSUE.
    bit          m_act = 1'b0;
    int          m_core, m_phase, m_last;
    int          m_ptr = 3;
    bit          m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_data;
    logic [7:0]  m_rdata [4] = '{default: 8'h00};
    logic [7:0]  ref_mem [32] = '{default: 8'h00};
    int unsigned m_cnt [4] = '{default: 0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_advance();
        int n;
        int k;
        if (i_rst) begin
            m_act = 1'b0;
            m_ptr = 3;
            for (int j = 0; j < 4; j++) begin
                m_rdata[j] = 8'h00;
                m_cnt[j]   = 0;
            end
            return;
        end
        if (m_act) begin
            if (m_phase == m_last) m_act = 1'b0;
            else                   m_phase++;
        end else begin
            n = (i_noc > 3'd4) ? 4 : int'(i_noc);
            for (int s = 1; s <= 4; s++) begin
                k = (m_ptr + s) % 4;
                if (k < n && i_req[k]) begin
                    m_act   = 1'b1;
                    m_core  = k;
                    m_we    = i_we[k];
                    m_addr  = i_addr[k*AW +: AW];
                    m_data  = i_wdata[k*DW +: DW];
                    m_last  = m_we ? 1 : 1 + RL;
                    m_phase = 0;
                    m_ptr   = k;
                    break;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [3:0] eg;
        logic [3:0] ed;
        bit er;
        bit ew;
        eg = 4'b0000;
        ed = 4'b0000;
        er = 1'b0;
        ew = 1'b0;
`ifdef ARB_STATS_EN
        for (int j = 0; j < 4; j++)
            check("grant_cnt", 64'(o_grant_cnt[j*16 +: 16]), 64'(m_cnt[j]));
`endif
        if (m_act) begin
            eg = 4'b0001 << m_core;
            if (m_phase == 0) begin
                er = !m_we;
                ew = m_we;
                check("dram_addr", 64'(o_dram_addr), 64'(m_addr));
                if (m_we) begin
                    check("dram_data", 64'(o_dram_data), 64'(m_data));
                    ref_mem[m_addr[4:0]] = m_data;
                end
                if (m_cnt[m_core] != 32'hFFFF) m_cnt[m_core]++;
            end
            if (m_phase == m_last) begin
                ed = eg;
                if (!m_we) m_rdata[m_core] = ref_mem[m_addr[4:0]];
            end
        end
        check("gnt",  64'(o_gnt),       64'(eg));
        check("done", 64'(o_done),      64'(ed));
        check("busy", 64'(o_busy),      64'(m_act));
        check("rden", 64'(o_dram_rden), 64'(er));
        check("wren", 64'(o_dram_wren), 64'(ew));
        for (int j = 0; j < 4; j++)
            check("rdata", 64'(o_rdata[j*DW +: DW]), 64'(m_rdata[j]));
    endtask

    task automatic randomize_inputs();
        i_we    = 4'($urandom);
        i_wdata = 32'($urandom);
        for (int j = 0; j < 4; j++) begin
            i_addr[j*AW +: AW] = 16'($urandom_range(0, 31));
            if (!i_req[j] && $urandom_range(0, 3) == 0) i_req[j] = 1'b1;
        end
        if ($urandom_range(0, 15) == 0) i_noc = 3'($urandom_range(0, 7));
    endtask

    task automatic run_cycle(input bit rnd);
        model_advance();
        @(posedge i_clk);
        @(negedge i_clk);
        cyc++;
        check_outputs();
        if (auto_drop) i_req = i_req & ~o_done;
        if (rnd) randomize_inputs();
    endtask

    int unsigned start, wc, dc;
    logic [7:0]  rd_at_done;
    int          order [$];
    bit          seen;

    initial begin
        i_rst   = 1'b1;
        i_noc   = 3'd4;
        i_req   = '0;
        i_we    = '0;
        i_addr  = '0;
        i_wdata = '0;
        run_cycle(0);
        run_cycle(0);
        check("rst_dram_addr", 64'(o_dram_addr), 64'h0);
        check("rst_dram_data", 64'(o_dram_data), 64'h0);
        i_rst = 1'b0;

        // Core 2 write 0xA5 to 0x0010.
        i_req = 4'b0100;
        i_we  = 4'b0100;
        i_addr[2*AW +: AW]  = 16'h0010;
        i_wdata[2*DW +: DW] = 8'hA5;
        start = cyc; wc = 0; dc = 0;
        for (int i = 0; i < 8; i++) begin
            run_cycle(0);
            if (o_dram_wren && wc == 0) wc = cyc - start;
            if (o_done[2] && dc == 0)   dc = cyc - start;
        end
        check("t1_wren_cycle", 64'(wc), 64'd1);
        check("t1_done_cycle", 64'(dc), 64'd2);

        // Core 2 read back 0x0010.
        i_req = 4'b0100;
        i_we  = 4'b0000;
        start = cyc; wc = 0; dc = 0; rd_at_done = 8'h00;
        for (int i = 0; i < 8; i++) begin
            run_cycle(0);
            if (o_dram_rden && wc == 0) wc = cyc - start;
            if (o_done[2] && dc == 0) begin
                dc = cyc - start;
                rd_at_done = o_rdata[2*DW +: DW];
            end
        end
        check("t2_rden_cycle", 64'(wc), 64'd1);
        check("t2_done_cycle", 64'(dc), 64'd3);
        check("t2_rdata",      64'(rd_at_done), 64'hA5);

        // All four held after reset: strict rotation starting at core 0.
        i_rst = 1'b1;
        run_cycle(0);
        i_rst = 1'b0;
        auto_drop = 1'b0;
        i_req = 4'hF;
        i_we  = 4'hF;
        for (int i = 0; i < 18; i++) begin
            run_cycle(0);
            check("t3_onehot", 64'($countones(o_gnt) <= 1), 64'd1);
            if (o_dram_wren) for (int j = 0; j < 4; j++) if (o_gnt[j]) order.push_back(j);
        end
        check("t3_issue_count", 64'(order.size() >= 5), 64'd1);
        for (int i = 0; i < 5; i++)
            check("t3_order", 64'((i < order.size()) ? order[i] : 9), 64'(i % 4));
        i_req = '0;
        auto_drop = 1'b1;
        for (int i = 0; i < 4; i++) run_cycle(0);

        // Cores 2/3 outside the active set until noc grows.
        i_noc = 3'd2;
        i_req = 4'b1100;
        i_we  = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            run_cycle(0);
            check("t4_busy_low", 64'(o_busy), 64'd0);
        end
        i_noc = 3'd3;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_cycle(0);
            if (o_gnt[2]) seen = 1'b1;
            check("t4_no_core3", 64'(o_gnt[3]), 64'd0);
        end
        check("t4_core2_granted", 64'(seen), 64'd1);
        i_req = '0;
        i_noc = 3'd4;
        for (int i = 0; i < 3; i++) run_cycle(0);

        // Reset in the middle of a read's WAIT phase.
        i_req = 4'b0010;
        i_we  = 4'b0000;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            run_cycle(0);
            if (m_act && !m_we && m_phase == 1) seen = 1'b1;
        end
        check("t5_reached_wait", 64'(seen), 64'd1);
        i_rst = 1'b1;
        #1;
        check("t5_rden", 64'(o_dram_rden), 64'd0);
        check("t5_wren", 64'(o_dram_wren), 64'd0);
        check("t5_gnt",  64'(o_gnt),       64'd0);
        check("t5_done", 64'(o_done),      64'd0);
        run_cycle(0);
        i_rst = 1'b0;
        i_req = 4'hF;
        i_we  = 4'hF;
        wc = 9;
        for (int i = 0; i < 4; i++) begin
            run_cycle(0);
            if (o_dram_wren && wc == 9) for (int j = 0; j < 4; j++) if (o_gnt[j]) wc = j;
        end
        check("t5_first_after_rst", 64'(wc), 64'd0);
        i_req = '0;
        for (int i = 0; i < 4; i++) run_cycle(0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) run_cycle(1);
        i_req = '0;
        for (int i = 0; i < 8; i++) run_cycle(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
